// File: rtl/ssd_bcd_scan_driver.sv
// rtl/ssd_bcd_scan_driver.sv - binary to BCD converter with 4-digit multiplexed seven-segment driver
module ssd_bcd_scan_driver #(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] value,
  output logic [3:0]  anode,
  output logic [6:0]  cathode,
  output logic [15:0] bcd,
  output logic        busy
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t      state, state_nxt;
  logic [12:0] shreg;
  logic [12:0] cap;
  logic [12:0] shown_bin;
  logic [15:0] scratch;
  logic [15:0] scratch_adj;
  logic [3:0]  bit_cnt;

  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       digit_idx;
  logic [3:0]       nibble;
  logic             blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (value != shown_bin) state_nxt = SHIFT;
      SHIFT:   if (bit_cnt == 4'd12) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Double-dabble correction applied before every shift.
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < 4; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // bcd and shown_bin only change together in LOAD, so the display never sees a partial result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg     <= '0;
      cap       <= '0;
      shown_bin <= '0;
      scratch   <= '0;
      bit_cnt   <= '0;
      bcd       <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (value != shown_bin) begin
            shreg   <= value;
            cap     <= value;
            scratch <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          {scratch, shreg} <= {scratch_adj, shreg} << 1;
          bit_cnt          <= bit_cnt + 4'd1;
        end
        LOAD: begin
          bcd       <= scratch;
          shown_bin <= cap;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_cnt == CNT_MAX) begin
      refresh_cnt <= '0;
      digit_idx   <= digit_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    anode  = 4'b1111;
    anode[digit_idx] = 1'b0;
    nibble = bcd[{digit_idx, 2'b00} +: 4];
    blank  = 1'b0;
    case (digit_idx)
      2'd1:    blank = (bcd[15:4] == 12'h000);
      2'd2:    blank = (bcd[15:8] == 8'h00);
      2'd3:    blank = (bcd[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
    cathode = (BLANK_LEADING && blank) ? 7'b1111111 : seg_decode(nibble);
  end

endmodule

// File: tb/tb_ssd_bcd_scan_driver.sv
// tb/tb_ssd_bcd_scan_driver.sv - directed self-checking bench for ssd_bcd_scan_driver
module tb_ssd_bcd_scan_driver;

  localparam logic [6:0] ZERO  = 7'b1000000;
  localparam logic [6:0] ONE   = 7'b1111001;
  localparam logic [6:0] TWO   = 7'b0100100;
  localparam logic [6:0] FOUR  = 7'b0011001;
  localparam logic [6:0] EIGHT = 7'b0000000;
  localparam logic [6:0] NINE  = 7'b0010000;
  localparam logic [6:0] BL    = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [12:0] value = '0;

  logic [3:0]  a_anode, b_anode, f_anode;
  logic [6:0]  a_cathode, b_cathode, f_cathode;
  logic [15:0] a_bcd, b_bcd, f_bcd;
  logic        a_busy, b_busy, f_busy;

  int n_pass = 0;
  int n_total = 0;
  int exp_cnt = 0;
  int exp_idx = 0;
  int exp_fidx = 0;

  ssd_bcd_scan_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .reset(reset), .value(value),
    .anode(a_anode), .cathode(a_cathode), .bcd(a_bcd), .busy(a_busy)
  );

  ssd_bcd_scan_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .value(value),
    .anode(b_anode), .cathode(b_cathode), .bcd(b_bcd), .busy(b_busy)
  );

  ssd_bcd_scan_driver #(.REFRESH_DIV(1), .BLANK_LEADING(1'b1)) dut_fast (
    .clk(clk), .reset(reset), .value(value),
    .anode(f_anode), .cathode(f_cathode), .bcd(f_bcd), .busy(f_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one edge; the scan reference counters follow the edge while reset is released.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      if (exp_cnt == 3) begin
        exp_cnt = 0;
        exp_idx = (exp_idx + 1) % 4;
      end else begin
        exp_cnt++;
      end
      exp_fidx = (exp_fidx + 1) % 4;
    end
    #1;
  endtask

  // eb/en hold {d3,d2,d1,d0} cathodes for the blanking and non-blanking instances.
  task automatic check_digits(input string tag, input logic [15:0] exp_bcd,
                              input logic [27:0] eb, input logic [27:0] en);
    logic [3:0] ea;
    for (int k = 0; k < 16; k++) begin
      ea = 4'hF;
      ea[exp_idx[1:0]] = 1'b0;
      if (k == 0) check($sformatf("%s bcd", tag), a_bcd, exp_bcd);
      check($sformatf("%s busy c%0d", tag, k), 16'(a_busy), 16'h0);
      check($sformatf("%s anode c%0d", tag, k), 16'(a_anode), 16'(ea));
      check($sformatf("%s cathode d%0d", tag, exp_idx), 16'(a_cathode), 16'(eb[7*exp_idx +: 7]));
      check($sformatf("%s nb anode c%0d", tag, k), 16'(b_anode), 16'(ea));
      check($sformatf("%s nb cathode d%0d", tag, exp_idx), 16'(b_cathode), 16'(en[7*exp_idx +: 7]));
      step();
    end
  endtask

  // Capture edge E0, busy through E13, new bcd on E14.
  task automatic conv(input string tag, input logic [15:0] old_bcd, input logic [15:0] new_bcd);
    step();
    for (int k = 1; k <= 14; k++) begin
      check($sformatf("%s busy E%0d", tag, k - 1), 16'(a_busy), 16'h1);
      if (k == 14) check($sformatf("%s bcd before E14", tag), a_bcd, old_bcd);
      step();
    end
    check($sformatf("%s busy after", tag), 16'(a_busy), 16'h0);
    check($sformatf("%s bcd", tag), a_bcd, new_bcd);
  endtask

  initial begin
    logic [3:0] ef;

    #3 reset = 1'b0;
    #1;
    check("rst anode", 16'(a_anode), 16'hE);
    check("rst cathode", 16'(a_cathode), 16'(ZERO));
    check("rst bcd", a_bcd, 16'h0000);
    check("rst busy", 16'(a_busy), 16'h0);
    step();
    step();
    reset = 1'b1;

    check_digits("hold0", 16'h0000, {BL, BL, BL, ZERO}, {ZERO, ZERO, ZERO, ZERO});

    value = 13'd8191;
    conv("v8191", 16'h0000, 16'h8191);
    check_digits("v8191", 16'h8191, {EIGHT, ONE, NINE, ONE}, {EIGHT, ONE, NINE, ONE});

    value = 13'd42;
    conv("v42", 16'h8191, 16'h0042);
    check_digits("v42", 16'h0042, {BL, BL, FOUR, TWO}, {ZERO, ZERO, FOUR, TWO});

    value = 13'd1234;
    step();
    for (int k = 1; k <= 14; k++) begin
      if (k == 5) value = 13'd5678;
      check($sformatf("v1234 busy E%0d", k - 1), 16'(a_busy), 16'h1);
      step();
    end
    check("v1234 bcd", a_bcd, 16'h1234);
    check("v1234 busy after", 16'(a_busy), 16'h0);
    conv("v5678", 16'h1234, 16'h5678);

    value = 13'd8191;
    step();
    for (int k = 1; k <= 7; k++) step();
    check("mid busy E7", 16'(a_busy), 16'h1);
    reset = 1'b0;
    exp_cnt = 0;
    exp_idx = 0;
    exp_fidx = 0;
    #1;
    check("async anode", 16'(a_anode), 16'hE);
    check("async cathode", 16'(a_cathode), 16'(ZERO));
    check("async bcd", a_bcd, 16'h0000);
    check("async busy", 16'(a_busy), 16'h0);
    check("async fast anode", 16'(f_anode), 16'hE);
    step();
    step();
    step();
    check("held bcd", a_bcd, 16'h0000);
    reset = 1'b1;
    conv("restart8191", 16'h0000, 16'h8191);

    value = 13'd9;
    conv("v9", 16'h8191, 16'h0009);
    check("fast bcd", f_bcd, 16'h0009);
    for (int k = 0; k < 8; k++) begin
      ef = 4'hF;
      ef[exp_fidx[1:0]] = 1'b0;
      check($sformatf("fast anode c%0d", k), 16'(f_anode), 16'(ef));
      check($sformatf("fast cathode c%0d", k), 16'(f_cathode), (exp_fidx == 0) ? 16'(NINE) : 16'(BL));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
